// File: rtl/rf16x8_rd_ctrl.sv
// Request front-end and storage for the 16x8 array; drives the mux-tree selects and captures read data.
// Reads: sel valid one edge after accept, response two edges after accept, held until rsp_ready.
module rf16x8_rd_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic [AW-1:0]    sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SEL, CAP, HOLD} state_t;

  // One extra bit so DEPTH == 2**AW is representable for the range compare.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  state_t           state_q;
  logic [AW-1:0]    sel_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en_d;
  logic             sel_in_range_d;
  logic [WIDTH-1:0] rd_word_d;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sel       = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  assign wr_en_d        = (state_q == IDLE) && req_valid && req_we && ({1'b0, req_addr} < DEPTH_LIM);
  assign sel_in_range_d = ({1'b0, sel_q} < DEPTH_LIM);

  // Words beyond DEPTH have no storage and read back as zero.
  always_comb begin
    rd_word_d = '0;
    if (sel_in_range_d) rd_word_d = mem_q[sel_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_d) begin
      mem_q[req_addr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && !req_we) begin
            sel_q   <= req_addr;
            state_q <= SEL;
          end
        end
        SEL: state_q <= CAP;
        CAP: begin
          rsp_rdata_q <= rd_word_d;
          rsp_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rf16x8_rd_ctrl.md
Name: rf16x8_rd_ctrl

Overview:
- Sequential front-end for the 16-word x 8-bit storage array.
- Accepts read and write requests over a valid/ready handshake and holds the storage flops.
- For reads, drives the registered select lines into the downstream switch-level 2:1 mux tree, waits one settle cycle, then captures the selected word into a response register.
- Sits directly upstream of the mux tree and feeds its select and data inputs.

Parameters:
- DEPTH, 16, number of words (must be <= 2**AW).
- WIDTH, 8, bits per word.
- AW, 4, address and select width.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AW  word address.
- req_wdata  input  WIDTH  write data.
- sel  output  AW  registered select lines to the mux tree; sel[0] drives the first mux rank.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  WIDTH  registered read data.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- **Reset** (rst_n low at a rising edge):
  - FSM goes to IDLE.
  - sel = 0, rsp_valid = 0, rsp_rdata = 0.
  - All DEPTH words are cleared to 0.
  - req_ready = 1 and busy = 0 from the first cycle after reset.
- **Reset mid-operation:** any in-flight read is aborted and no response is issued. rsp_valid is 0 after the reset edge even if it was 1 before.
- **FSM states:** IDLE, SEL, CAP, HOLD.
  - req_ready is combinational: req_ready = (state == IDLE).
  - busy is combinational: busy = (state != IDLE).
- **IDLE:**
  - Write accept (req_valid & req_we): mem[req_addr] <= req_wdata at that edge. FSM stays IDLE. No response is generated. Back-to-back writes run at 1 per cycle.
  - Read accept (req_valid & !req_we): sel <= req_addr, then go to SEL.
- **SEL:** one settle cycle for the mux tree. sel is held. Go to CAP.
- **CAP:** rsp_rdata <= mem[sel], rsp_valid <= 1. Go to HOLD.
- **HOLD:**
  - rsp_valid and rsp_rdata are held stable until rsp_ready = 1.
  - On the handshake edge: rsp_valid <= 0, go to IDLE.
  - If rsp_ready is already high on the first HOLD cycle, the response lasts exactly 1 cycle.
- **sel stability:** sel changes only on a read accept. It keeps its last value otherwise, including during writes.
- **Latency:**
  - Read accepted at edge N: rsp_valid is high after edge N+2.
  - Minimum read throughput: 1 read per 4 cycles (accept, SEL, CAP, HOLD handshake).
- **Read-after-write:** a write at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
- **Out-of-range addresses** (req_addr >= DEPTH, only possible when DEPTH < 2**AW):
  - Writes are ignored.
  - Reads complete normally and return 0.
- **Request signals outside IDLE:** req_valid, req_we, req_addr and req_wdata are don't-care; nothing is accepted while req_ready = 0.
- **rsp_ready outside HOLD:** ignored.
- **No X propagation:** no output is X after the first reset edge.

Test Plan:
- **Reset:** hold rst_n = 0 for 2 edges mid-read (state CAP) -> rsp_valid = 0, sel = 0, rsp_rdata = 0, req_ready = 1. A subsequent read of addr 5 returns 0x00.
- **Write/read:** write 0xA5 to addr 3, then read addr 3 with rsp_ready = 1 -> sel = 3 one edge after accept, rsp_valid high 2 edges after accept, rsp_rdata = 0xA5, req_ready high again one edge after the response handshake.
- **Backpressure:** write 0x3C to addr 15, read addr 15 with rsp_ready = 0 for 5 cycles, then 1 -> rsp_valid and rsp_rdata = 0x3C held stable for all 6 cycles, then drop.
- **Back-to-back writes:** write addr 0..15 with data = addr*0x11 on consecutive cycles -> req_ready high throughout. Reading all 16 addresses returns 0x00, 0x11, …, 0xFF, and sel tracks each address.
- **Read-after-write and requests while busy:** write 0x7E to addr 9, read addr 9 on the next cycle -> 0x7E. Assert req_valid with a write to addr 9 (data 0x00) while busy -> ignored; a later read still returns 0x7E.
- **Out-of-range (DEPTH = 12):** write 0xFF to addr 13 -> no storage change. Read addr 13 -> rsp_rdata = 0x00.
